// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs,
// ALU control codes, mux selects and the FSM state type.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_OUT = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RTYPE,
        S_RWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_IMMEX,
        S_IMMWB
    } state_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags
// functs the datapath does not implement.
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       illegal
);

    always_comb begin
        alu_ctl = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/mem/writeback
// and drives every datapath select and enable, with a memory timeout.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_ctl,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          ext_q, ext_d;
    logic          waiting;
    logic [2:0]    fn_ctl;
    logic          fn_bad;

    alu_dec u_alu_dec (
        .funct   (funct),
        .alu_ctl (fn_ctl),
        .illegal (fn_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            ext_q     <= ext_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_err_d  = mem_err_q;
        ext_d      = ext_q;
        waiting    = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        ext_zero   = 1'b0;
        alu_ctl    = ALU_AND;
        pc_src     = PC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_4;
                alu_ctl   = ALU_ADD;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
                else           waiting = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM4;
                alu_ctl   = ALU_ADD;
                case (opcode)
                    OP_RTYPE:        state_d = S_RTYPE;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:          state_d = S_IMMEX;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_ctl   = fn_ctl;
                if (fn_bad) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_RWB;
                end
            end
            S_RWB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctl   = ALU_ADD;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else           waiting = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctl    = ALU_SUB;
                pc_src     = PC_OUT;
                pc_we      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_JMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ANDI: begin
                        alu_ctl  = ALU_AND;
                        ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        alu_ctl  = ALU_OR;
                        ext_zero = 1'b1;
                    end
                    default: alu_ctl = ALU_ADD;
                endcase
                ext_d   = ext_zero;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                reg_we     = 1'b1;
                ext_zero   = ext_q;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // A timeout abandons the access; no write enable was raised while waiting.
        if (waiting) begin
            if (TMO_EN && cnt_q == CNT_LAST) begin
                mem_err_d = 1'b1;
                state_d   = S_FETCH;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction phase model plus
// directed latency, stall, timeout, illegal and reset checks.
module tb_mc_ctrl;

    localparam int TMO = 6;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4;
    localparam int K_ADDI = 5, K_ANDI = 6, K_ORI = 7;
    localparam int K_BADOP = 8, K_BADFN = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst;
    logic       mem_to_reg, alu_src_a, ext_zero, instr_done, illegal;
    logic       mem_err;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctl;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
        logic       mem_err;
    } ov_t;

    ov_t vec;
    ov_t trace [64];

    int checks = 0;
    int passes = 0;

    bit m_idle = 1'b1;
    bit m_err = 1'b0;
    int m_ph = 0;
    int m_w = 0;
    int m_cnt = 0;

    mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_ctl    (alu_ctl),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    assign vec = {pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctl,
                  pc_src, instr_done, illegal, mem_err};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'd0: begin
                case (fn)
                    6'd32, 6'd34, 6'd36, 6'd37, 6'd42: return K_R;
                    default: return K_BADFN;
                endcase
            end
            6'd35: return K_LW;
            6'd43: return K_SW;
            6'd4:  return K_BEQ;
            6'd2:  return K_J;
            6'd8:  return K_ADDI;
            6'd12: return K_ANDI;
            6'd13: return K_ORI;
            default: return K_BADOP;
        endcase
    endfunction

    function automatic int len_of(input int k);
        case (k)
            K_LW:         return 5;
            K_BEQ, K_J:   return 3;
            K_BADOP:      return 2;
            K_BADFN:      return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [2:0] rfn(input logic [5:0] fn);
        case (fn)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    // Expected outputs for phase ph (0 = fetch) of an instruction of kind k.
    function automatic ov_t model_out(input int k, input int ph, input logic mr,
                                      input logic z, input logic [5:0] fn,
                                      input bit err);
        ov_t o;
        o = '0;
        o.mem_err = err;
        if (ph == 0) begin
            o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.alu_ctl = 3'b010;
            o.ir_we = mr; o.pc_we = mr;
        end else if (ph == 1) begin
            o.alu_src_b = 2'b11; o.alu_ctl = 3'b010;
            if (k == K_BADOP) begin o.illegal = 1'b1; o.instr_done = 1'b1; end
        end else begin
            case (k)
                K_R, K_BADFN: begin
                    if (ph == 2) begin
                        o.alu_src_a = 1'b1;
                        o.alu_ctl = (k == K_R) ? rfn(fn) : 3'b000;
                        if (k == K_BADFN) begin
                            o.illegal = 1'b1; o.instr_done = 1'b1;
                        end
                    end else begin
                        o.reg_we = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
                    end
                end
                K_LW, K_SW: begin
                    if (ph == 2) begin
                        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctl = 3'b010;
                    end else if (k == K_LW && ph == 3) begin
                        o.mem_rd = 1'b1; o.iord = 1'b1;
                    end else if (k == K_LW) begin
                        o.reg_we = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    end else begin
                        o.mem_wr = 1'b1; o.iord = 1'b1; o.instr_done = mr;
                    end
                end
                K_BEQ: begin
                    o.alu_src_a = 1'b1; o.alu_ctl = 3'b110; o.pc_src = 2'b01;
                    o.pc_we = z; o.instr_done = 1'b1;
                end
                K_J: begin
                    o.pc_src = 2'b10; o.pc_we = 1'b1; o.instr_done = 1'b1;
                end
                default: begin
                    o.ext_zero = (k != K_ADDI);
                    if (ph == 2) begin
                        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                        o.alu_ctl = (k == K_ADDI) ? 3'b010 :
                                    (k == K_ANDI) ? 3'b000 : 3'b001;
                    end else begin
                        o.reg_we = 1'b1; o.instr_done = 1'b1;
                    end
                end
            endcase
        end
        return o;
    endfunction

    always @(negedge clk) begin
        ov_t e;
        int  k;
        bit  wt;
        k = kind_of(opcode, funct);
        if (rst) begin
            e = '0; m_idle = 1'b1; m_ph = 0; m_w = 0; m_err = 1'b0;
        end else if (m_idle) begin
            e = '0; m_idle = 1'b0;
        end else begin
            e = model_out(k, m_ph, mem_ready, zero, funct, m_err);
            wt = !mem_ready &&
                 (m_ph == 0 || ((k == K_LW || k == K_SW) && m_ph == 3));
            if (wt) begin
                m_w++;
                if (m_w == TMO) begin
                    m_err = 1'b1; m_w = 0; m_ph = 0; m_cnt++;
                end
            end else begin
                m_w = 0;
                if (m_ph == len_of(k) - 1) begin
                    m_ph = 0; m_cnt++;
                end else begin
                    m_ph++;
                end
            end
        end
        chk("cycle", 32'(vec), 32'(e));
    end

    // Runs one instruction from a FETCH cycle until the model sees it end.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input bit rnd, input logic z, input int stall,
                       output int cyc);
        int start;
        int left;
        start = m_cnt;
        left = stall;
        cyc = 0;
        opcode = op;
        funct = fn;
        while (1) begin
            zero = rnd ? 1'($urandom_range(0, 1)) : z;
            if (iord && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else if (rnd && !iord) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            trace[cyc] = vec;
            cyc++;
            @(posedge clk);
            #1;
            if (m_cnt != start) break;
            if (cyc >= 64) begin
                chk("run_bound", 32'(cyc), 32'd0);
                break;
            end
        end
    endtask

    function automatic int count_f(input int n, input int f);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            case (f)
                0: s += int'(trace[i].reg_we);
                1: s += int'(trace[i].mem_wr);
                default: s += int'(trace[i].instr_done);
            endcase
        end
        return s;
    endfunction

    logic [5:0] ops [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8,
                             6'd12, 6'd13, 6'd63, 6'd17};
    logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd7};

    initial begin
        int c;
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_zero", 32'(vec), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fetch_rd", 32'({mem_rd, alu_src_b}), 32'b101);
        @(posedge clk); #1;

        run(6'd35, 6'd0, 1'b0, 1'b0, 0, c);
        chk("lw_cycles", 32'(c), 32'd5);
        chk("lw_wb", 32'({trace[4].reg_we, trace[4].mem_to_reg}), 32'b11);
        chk("lw_done", 32'(count_f(c, 2)), 32'd1);

        run(6'd4, 6'd0, 1'b0, 1'b1, 0, c);
        chk("beq_t_cycles", 32'(c), 32'd3);
        chk("beq_t_pc", 32'({trace[2].pc_we, trace[2].pc_src}), 32'b101);
        run(6'd4, 6'd0, 1'b0, 1'b0, 0, c);
        chk("beq_f_cycles", 32'(c), 32'd3);
        chk("beq_f_pcwe", 32'(trace[2].pc_we), 32'd0);

        run(6'd13, 6'd0, 1'b0, 1'b0, 0, c);
        chk("ori_ex", 32'({trace[2].ext_zero, trace[2].alu_ctl}), 32'b1001);
        chk("ori_wb_ext", 32'(trace[3].ext_zero), 32'd1);
        run(6'd8, 6'd0, 1'b0, 1'b0, 0, c);
        chk("addi_ex", 32'({trace[2].ext_zero, trace[2].alu_ctl}), 32'b0010);
        chk("addi_cycles", 32'(c), 32'd4);

        run(6'd43, 6'd0, 1'b0, 1'b0, 5, c);
        chk("sw_stall_cycles", 32'(c), 32'd9);
        chk("sw_stall_wr", 32'(count_f(c, 1)), 32'd6);

        run(6'd43, 6'd0, 1'b0, 1'b0, 1000, c);
        chk("tmo_cycles", 32'(c), 32'(3 + TMO));
        chk("tmo_err", 32'(mem_err), 32'd1);
        chk("tmo_nodone", 32'(count_f(c, 2)), 32'd0);
        chk("tmo_fetch", 32'(mem_rd & ~iord), 32'd1);

        run(6'd63, 6'd0, 1'b0, 1'b0, 0, c);
        chk("badop_cycles", 32'(c), 32'd2);
        chk("badop_ill", 32'(trace[1].illegal), 32'd1);
        chk("badop_nowe", 32'(count_f(c, 0)), 32'd0);
        run(6'd0, 6'd7, 1'b0, 1'b0, 0, c);
        chk("badfn_cycles", 32'(c), 32'd3);
        chk("badfn_ill", 32'(trace[2].illegal), 32'd1);
        chk("badfn_nowe", 32'(count_f(c, 0)), 32'd0);

        opcode = 6'd0;
        funct = 6'd32;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rwb_we", 32'(reg_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drop", 32'({reg_we, pc_we, mem_wr, instr_done}), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            run(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)],
                1'b1, 1'b0, $urandom_range(0, 8), c);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the single-memory RISC datapath. Sequences PC, IR, register file, ALU, sign/zero extender and memory through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Decodes `opcode[5:0]` and `funct[5:0]` from the IR and drives every datapath mux select and write enable.
- Stalls on a memory ready handshake.
- Sits between the IR/flags and the datapath mux/enable inputs.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before raising `mem_err`. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_we  out  1  PC load
- ir_we  out  1  IR load
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- reg_we  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
- ext_zero  out  1  extender mode: 0=sign-extend imm[15:0] to 32 bits, 1=zero-extend
- alu_ctl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  one-cycle pulse on an unknown opcode or funct
- mem_err  out  1  sticky timeout flag, cleared only by rst

Interface rule (already decided): one clock, `clk`. Reset `rst` is asynchronous and active-high.

Behaviour:
- Reset: state=IDLE, `mem_err`=0, timeout counter=0. All outputs are 0 while in IDLE.
- Reset release: IDLE goes to FETCH on the first clock after `rst` deasserts.
- Moore outputs: all outputs decode from the registered state, except those gated by `mem_ready`/`zero` noted below. Anything not listed in a state is 0.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Drives `mem_rd`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctl`=add, `pc_src`=00.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_ctl`=add (precomputes branch target), `ext_zero`=0.
  - Next state by opcode:
    - 000000 -> RTYPE
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> IMMEX
    - 001100 (andi) -> IMMEX
    - 001101 (ori) -> IMMEX
    - anything else -> FETCH with `illegal`=1 and `instr_done`=1
- RTYPE:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_ctl` from `funct`: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown `funct` -> FETCH with `illegal` and `instr_done` pulsed. Otherwise -> RWB.
- RWB: drives `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0 and pulses `instr_done`, then -> FETCH.
- MEMADR: drives `alu_src_a`=1, `alu_src_b`=10, `alu_ctl`=add, `ext_zero`=0. lw -> MEMRD, sw -> MEMWR.
- MEMRD: drives `mem_rd`=1, `iord`=1. Holds until `mem_ready`, then -> MEMWB.
- MEMWB: drives `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1 and pulses `instr_done`, then -> FETCH.
- MEMWR: drives `mem_wr`=1, `iord`=1. Holds until `mem_ready`; `instr_done` pulses in that same cycle, then -> FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_ctl`=sub, `pc_src`=01.
  - `pc_we` = `zero`. Pulses `instr_done`, then -> FETCH.
- JUMP: drives `pc_src`=10, `pc_we`=1 and pulses `instr_done`, then -> FETCH.
- IMMEX:
  - Drives `alu_src_a`=1, `alu_src_b`=10.
  - `alu_ctl` = add for addi, and for andi, or for ori.
  - `ext_zero` = 1 for andi/ori, 0 for addi.
  - Then -> IMMWB.
- IMMWB: drives `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. `ext_zero` is held at the IMMEX value. Pulses `instr_done`, then -> FETCH.
- Latency with `mem_ready` high on the first request: R/addi/andi/ori 4 cycles, lw 5, sw 4, beq 3, j 3. Each stall cycle adds 1.
- Timeout:
  - The counter increments every cycle spent waiting in FETCH/MEMRD/MEMWR with `mem_ready`=0, and clears on any state change.
  - When it reaches MEM_TIMEOUT: `mem_err` is set, the FSM goes to FETCH and the in-flight instruction is abandoned (no `reg_we`, no `pc_we`).
  - `mem_err` stays set and the FSM keeps running.
- `rst` asserted mid-instruction: the FSM goes immediately (asynchronously) to IDLE and all writes drop in the same cycle.

Decomposition:
- Package `mc_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI), funct constants, ALU_CTL encodings, ALUSRCB/PCSRC encodings, and the state enum (4-bit binary).
- Sub-module `alu_dec`: combinational `funct` -> `alu_ctl` plus an illegal flag, instantiated once in RTYPE decode.

Test Plan:
- Reset: rst=1 for 3 cycles, release -> one IDLE cycle with all outputs 0, then FETCH with `mem_rd`=1 and `alu_src_b`=01.
- lw (opcode 100011), `mem_ready` tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_we`=1 and `mem_to_reg`=1 in cycle 5. `instr_done` pulses once.
- beq (000100): zero=1 -> `pc_we`=1 and `pc_src`=01 in cycle 3. zero=0 -> `pc_we`=0. Both finish in 3 cycles.
- ori (001101) -> `ext_zero`=1 and `alu_ctl`=001 in IMMEX. addi (001000) -> `ext_zero`=0 and `alu_ctl`=010.
- sw with `mem_ready` low for 5 cycles -> `mem_wr` held 6 cycles, total 9 cycles. With MEM_TIMEOUT=4 and `mem_ready` stuck at 0 -> `mem_err`=1 after 4 wait cycles, return to FETCH, no write.
- opcode 111111, and opcode 000000 with funct 000111 -> `illegal` pulses and FETCH follows with no `reg_we`. Asserting `rst` during RWB -> `reg_we` drops in the same cycle.
